watch_set_ctrl: RTL and testbench

WATCH_SET_CTRL -- requirements
Module: watch_set_ctrl

---
 rtl/watch_pkg.sv | 21 ++
 rtl/pls_gen.sv | 60 ++++++
 rtl/watch_set_ctrl.sv | 90 +++++++++
 tb/tb_watch_set_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared definitions for the watch set controller: mode encodings,
// default pulse timing and the width of the pulse timing counters.
package watch_pkg;

  typedef enum logic [1:0] {
    M_RUN     = 2'd0,
    M_SET_HR  = 2'd1,
    M_SET_MIN = 2'd2,
    M_SET_SEC = 2'd3
  } mode_e;

  localparam int PW_DEF  = 4;
  localparam int GAP_DEF = 4;

  function automatic int cnt_w(input int pw, input int gap);
    return $clog2((pw > gap) ? pw : gap) + 1;
  endfunction

  localparam int CNT_W = cnt_w(PW_DEF, GAP_DEF);

endpackage

// File: rtl/pls_gen.sv
// Fixed-width pulse generator with a minimum low gap and a single pending
// slot for a trigger that arrives while the output is busy.
module pls_gen
  import watch_pkg::*;
#(
  parameter int PW  = PW_DEF,
  parameter int GAP = GAP_DEF,
  localparam int CW = cnt_w(PW, GAP)
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  input  logic clr_pend,
  output logic pls,
  output logic busy
);

  logic          gap_q;
  logic          pend_q;
  logic [CW-1:0] cnt_q;
  logic          hi_end;
  logic          gap_end;
  logic          fire;

  assign busy    = pls | gap_q;
  assign hi_end  = pls && (cnt_q == CW'(PW - 1));
  assign gap_end = gap_q && (cnt_q == CW'(GAP - 1));
  // The last gap cycle may launch the next pulse, so no extra idle cycle is added.
  assign fire    = (!busy && trig) || (gap_end && (trig || (pend_q && !clr_pend)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pls    <= 1'b0;
      gap_q  <= 1'b0;
      pend_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (fire) begin
        pls   <= 1'b1;
        gap_q <= 1'b0;
        cnt_q <= '0;
      end else if (hi_end) begin
        pls   <= 1'b0;
        gap_q <= 1'b1;
        cnt_q <= '0;
      end else if (gap_end) begin
        gap_q <= 1'b0;
        cnt_q <= '0;
      end else if (busy) begin
        cnt_q <= cnt_q + CW'(1);
      end

      if (clr_pend || fire)
        pend_q <= 1'b0;
      else if (trig && busy)
        pend_q <= 1'b1;
    end
  end

endmodule

// File: rtl/watch_set_ctrl.sv
// Watch time-setting controller: routes the 1 Hz tick, counter carries and
// the up button to the seconds/minutes/hours pulse inputs depending on mode.
module watch_set_ctrl
  import watch_pkg::*;
#(
  parameter int PW  = PW_DEF,
  parameter int GAP = GAP_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       sec_plso,
  input  logic       min_plso,
  output logic       sec_pls,
  output logic       min_pls,
  output logic       hr_pls,
  output logic       sec_clr,
  output logic [1:0] mode,
  output logic       blink
);

  // bit order: 0 btn_mode, 1 btn_up, 2 sec_plso, 3 min_plso
  logic [3:0] sync_p0, sync_p1, sync_p2;
  logic       mode_ev, up_ev, sec_fall, min_fall;
  logic [3:0] trig;
  logic [3:0] pls_v;
  logic [3:0] busy_v;
  mode_e      mode_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      sync_p2 <= '0;
    end else begin
      sync_p0 <= {min_plso, sec_plso, btn_up, btn_mode};
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  // Edge detection on the synchronized copies
  assign mode_ev  = sync_p1[0] & ~sync_p2[0];
  assign up_ev    = sync_p1[1] & ~sync_p2[1] & ~mode_ev;
  assign sec_fall = ~sync_p1[2] & sync_p2[2];
  assign min_fall = ~sync_p1[3] & sync_p2[3];

  always_comb begin
    trig    = '0;
    trig[0] = (mode_q == M_RUN) && tick;
    trig[1] = ((mode_q == M_RUN) && sec_fall) || ((mode_q == M_SET_MIN) && up_ev);
    trig[2] = ((mode_q == M_RUN) && min_fall) || ((mode_q == M_SET_HR) && up_ev);
    trig[3] = (mode_q == M_SET_SEC) && up_ev;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q <= M_RUN;
      blink  <= 1'b0;
    end else if (mode_ev) begin
      mode_q <= mode_e'(mode_q + 2'd1);
      blink  <= (mode_q != M_SET_SEC);
    end else if (mode_q == M_RUN) begin
      blink  <= 1'b0;
    end else if (tick) begin
      blink  <= ~blink;
    end
  end

  // Pulse stage: 0 sec_pls, 1 min_pls, 2 hr_pls, 3 sec_clr
  for (genvar i = 0; i < 4; i++) begin : g_pls
    pls_gen #(.PW(PW), .GAP(GAP)) u_pls (
      .clk      (clk),
      .rst      (rst),
      .trig     (trig[i]),
      .clr_pend (mode_ev),
      .pls      (pls_v[i]),
      .busy     (busy_v[i])
    );
  end

  assign sec_pls = pls_v[0];
  assign min_pls = pls_v[1];
  assign hr_pls  = pls_v[2];
  assign sec_clr = pls_v[3];
  assign mode    = mode_q;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Bench for watch_set_ctrl: timestamp-based reference model compared every
// cycle, directed literal scenarios, then randomized stimulus.
module tb_watch_set_ctrl;

  localparam int PW  = 4;
  localparam int GAP = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0, btn_mode = 1'b0, btn_up = 1'b0;
  logic       sec_plso = 1'b0, min_plso = 1'b0;
  logic       sec_pls, min_pls, hr_pls, sec_clr, blink;
  logic [1:0] mode;

  watch_set_ctrl #(.PW(PW), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .tick(tick), .btn_mode(btn_mode), .btn_up(btn_up),
    .sec_plso(sec_plso), .min_plso(min_plso), .sec_pls(sec_pls), .min_pls(min_pls),
    .hr_pls(hr_pls), .sec_clr(sec_clr), .mode(mode), .blink(blink)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: each output remembers the edge of its last rise
  int       ecnt = 0;
  int       t_rise[4] = '{-1000, -1000, -1000, -1000};
  bit       pend[4] = '{0, 0, 0, 0};
  int       m = 0;
  bit       blk = 0;
  bit [3:0] d1 = '0, d2 = '0, d3 = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d want %0d", name, ecnt, act, exp);
    end
  endtask

  task automatic model_step();
    bit mev, uev, fs, fm;
    bit trg[4];
    ecnt++;
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin t_rise[i] = -1000; pend[i] = 0; end
      d1 = '0; d2 = '0; d3 = '0; m = 0; blk = 0;
      return;
    end
    mev = d2[0] && !d3[0];
    uev = d2[1] && !d3[1] && !mev;
    fs  = !d2[2] && d3[2];
    fm  = !d2[3] && d3[3];
    trg[0] = (m == 0) && tick;
    trg[1] = ((m == 0) && fs) || ((m == 2) && uev);
    trg[2] = ((m == 0) && fm) || ((m == 1) && uev);
    trg[3] = (m == 3) && uev;
    for (int i = 0; i < 4; i++) begin
      if ((ecnt - t_rise[i] >= PW + GAP) && (trg[i] || (pend[i] && !mev))) begin
        t_rise[i] = ecnt; pend[i] = 0;
      end else if (mev) pend[i] = 0;
      else if (trg[i]) pend[i] = 1;
    end
    if (mev) begin m = (m + 1) % 4; blk = (m != 0); end
    else if (m == 0) blk = 0;
    else if (tick) blk = !blk;
    d3 = d2; d2 = d1;
    d1 = {min_plso, sec_plso, btn_up, btn_mode};
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("sec_pls", sec_pls, 0); chk("min_pls", min_pls, 0); chk("hr_pls", hr_pls, 0);
      chk("sec_clr", sec_clr, 0); chk("mode", mode, 0); chk("blink", blink, 0);
    end else begin
      chk("sec_pls", sec_pls, int'(ecnt - t_rise[0] < PW));
      chk("min_pls", min_pls, int'(ecnt - t_rise[1] < PW));
      chk("hr_pls", hr_pls, int'(ecnt - t_rise[2] < PW));
      chk("sec_clr", sec_clr, int'(ecnt - t_rise[3] < PW));
      chk("mode", mode, m);
      chk("blink", blink, blk);
    end
  end

  // Rise counters for the directed scenarios
  int r_sec = 0, r_min = 0, r_hr = 0, h_clr = 0, e_min = -1, e_hr = -1;
  logic p_sec = 0, p_min = 0, p_hr = 0;
  initial forever begin
    @(negedge clk);
    if (sec_pls && !p_sec) r_sec++;
    if (min_pls && !p_min) begin r_min++; if (e_min < 0) e_min = ecnt; end
    if (hr_pls && !p_hr) begin r_hr++; if (e_hr < 0) e_hr = ecnt; end
    if (sec_clr) h_clr++;
    p_sec = sec_pls; p_min = min_pls; p_hr = hr_pls;
  end

  task automatic zero_cnt();
    r_sec = 0; r_min = 0; r_hr = 0; h_clr = 0; e_min = -1; e_hr = -1;
  endtask

  task automatic pedge(input int n = 1);
    for (int i = 0; i < n; i++) begin @(posedge clk); #2; end
  endtask

  task automatic press_mode(input bit with_up);
    btn_mode = 1; btn_up = with_up; pedge(3);
    btn_mode = 0; btn_up = 0; pedge(6);
  endtask

  int f_edge;

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_mode", mode, 0); chk("rst_sec_pls", sec_pls, 0); chk("rst_blink", blink, 0);
    pedge(2); rst = 1; pedge(4);

    // Single tick: high for PW cycles starting one cycle after the tick
    tick = 1; pedge(); tick = 0;
    for (int i = 0; i < PW; i++) begin @(negedge clk); chk("tick_hi", sec_pls, 1); end
    @(negedge clk); chk("tick_lo", sec_pls, 0);
    pedge(12);

    // Three ticks two cycles apart: second deferred past the gap, third dropped
    zero_cnt();
    for (int i = 0; i < 3; i++) begin tick = 1; pedge(); tick = 0; pedge(); end
    pedge(30);
    chk("tick_pend_count", r_sec, 2);

    // Both carries fall together: one min and one hr pulse, same rise edge
    sec_plso = 1; min_plso = 1; pedge(6);
    zero_cnt();
    sec_plso = 0; min_plso = 0; f_edge = ecnt + 1; pedge(20);
    chk("carry_min_cnt", r_min, 1); chk("carry_hr_cnt", r_hr, 1);
    chk("carry_min_edge", e_min, f_edge + 2); chk("carry_hr_edge", e_hr, f_edge + 2);

    // Reset in the middle of a pulse
    tick = 1; pedge(); tick = 0; pedge();
    rst = 0; #1;
    chk("midrst_sec", sec_pls, 0); chk("midrst_min", min_pls, 0); chk("midrst_hr", hr_pls, 0);
    chk("midrst_clr", sec_clr, 0); chk("midrst_mode", mode, 0); chk("midrst_blink", blink, 0);
    pedge(); rst = 1; zero_cnt(); pedge(20);
    chk("midrst_nopulse", r_sec, 0);

    // Two mode steps, then five up presses in SET_MIN with ticks running
    press_mode(0); press_mode(0);
    chk("setmin_mode", mode, 2);
    zero_cnt();
    for (int k = 0; k < 5; k++)
      for (int c = 0; c < 20; c++) begin
        btn_up = (c < 2); tick = (c % 4 == 1); pedge();
      end
    btn_up = 0; tick = 0; pedge(10);
    chk("setmin_min_cnt", r_min, 5); chk("setmin_sec_cnt", r_sec, 0); chk("setmin_hr_cnt", r_hr, 0);

    // SET_SEC: up clears seconds; simultaneous mode+up only advances mode
    press_mode(0);
    chk("setsec_mode", mode, 3);
    zero_cnt(); btn_up = 1; pedge(2); btn_up = 0; pedge(15);
    chk("setsec_clr_cycles", h_clr, PW);
    zero_cnt(); press_mode(1); pedge(10);
    chk("both_mode", mode, 0); chk("both_clr_cycles", h_clr, 0);

    // Randomized stimulus
    for (int c = 0; c < 4000; c++) begin
      tick = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 39) == 0) btn_mode = ~btn_mode;
      if ($urandom_range(0, 7) == 0) btn_up = ~btn_up;
      if ($urandom_range(0, 9) == 0) sec_plso = ~sec_plso;
      if ($urandom_range(0, 9) == 0) min_plso = ~min_plso;
      if ($urandom_range(0, 799) == 0) begin
        rst = 0; pedge($urandom_range(1, 2)); rst = 1;
      end
      pedge();
    end
    tick = 0; pedge(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
